// File: rtl/seven_segment_scan.sv
// Multiplexed hex display scanner with frame-synchronous double buffering.
// One digit is driven per slot, with optional all-off gaps between slots.
module seven_segment_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 12000,
    parameter int GAP    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [3:0]            nibble,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame,
    output logic                  pending
);

    localparam int CMAX = (DIV > GAP) ? DIV : GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = $clog2(DIGITS);

    typedef enum logic {
        S_SHOW,
        S_GAP
    } st_t;

    st_t                  st, st_n;
    logic [IW-1:0]        idx, idx_n;
    logic [CW-1:0]        div_cnt, cnt_n;
    logic [4*DIGITS-1:0]  disp_val, pend_val;
    logic [DIGITS-1:0]    disp_dp, pend_dp;
    logic                 disp_blz, pend_blz, pend_flag;

    logic                 show_end, gap_end, adv, wrap;
    logic [DIGITS-1:0]    blank;
    logic                 hz;

    assign show_end = (st == S_SHOW) && (div_cnt == CW'(DIV - 1));
    assign gap_end  = (GAP > 0) && (st == S_GAP) && (div_cnt == CW'(GAP - 1));
    assign adv      = (GAP > 0) ? gap_end : show_end;
    assign wrap     = adv && (idx == IW'(DIGITS - 1));

    always_comb begin
        st_n  = st;
        idx_n = idx;
        cnt_n = div_cnt + 1'b1;
        if (show_end || gap_end) begin
            cnt_n = '0;
        end
        if (show_end && (GAP > 0)) begin
            st_n = S_GAP;
        end else if (gap_end) begin
            st_n = S_SHOW;
        end
        if (adv) begin
            idx_n = wrap ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st        <= S_SHOW;
            idx       <= '0;
            div_cnt   <= '0;
            disp_val  <= '0;
            disp_dp   <= '0;
            disp_blz  <= 1'b0;
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_blz  <= 1'b0;
            pend_flag <= 1'b0;
        end else begin
            st      <= st_n;
            idx     <= idx_n;
            div_cnt <= cnt_n;
            if (wrap && pend_flag) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
                disp_blz <= pend_blz;
            end
            // A load on the commit cycle lands after the old contents move out
            if (load) begin
                pend_val  <= value;
                pend_dp   <= dp_in;
                pend_blz  <= blank_lz;
                pend_flag <= 1'b1;
            end else if (wrap) begin
                pend_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        hz    = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            hz       = hz && (disp_val[4*i +: 4] == 4'h0);
            blank[i] = disp_blz && hz;
        end
    end

    always_comb begin
        digit_en = '1;
        nibble   = 4'h0;
        dp       = 1'b0;
        if ((st == S_SHOW) && !blank[idx]) begin
            digit_en[idx] = 1'b0;
            nibble        = disp_val[{idx, 2'b00} +: 4];
            dp            = disp_dp[idx];
        end
    end

    assign frame   = wrap;
    assign pending = pend_flag;

endmodule
